// File: rtl/uart_rx_port.sv
// 8N1 UART receiver presenting a received byte and sticky status bits to a polling CPU.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_rx_port #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       arx_ack,
    output logic [7:0] arx_data,
    output logic       arx_ready,
    output logic       arx_busy,
    output logic       arx_frame_err,
    output logic       arx_overrun
);

    localparam int DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_C    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_rx_port: OVERSAMPLE must be even and >= 8; FIFO_DEPTH a power of 2 >= 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nx;
    logic            rxd_meta, rxd_sync, rxd_prev;
    logic [1:0]      sync_fill;
    logic            rx_fall;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [SW-1:0]   samp_cnt;
    logic            samp_a, samp_b, maj;
    logic            mid_last, bit_end;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            line_seen_idle;
    logic            start_det, deliver;
    logic            ack_q, ack_rise;
    logic            pop, store_full;

    // sync_fill marks when rxd_sync holds a real line sample rather than its reset value,
    // so the forced-high reset state can never count as an idle line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rxd_meta  <= 1'b1;
            rxd_sync  <= 1'b1;
            rxd_prev  <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            // NOTE: non-blocking so each stage captures the previous stage's old value.
            rxd_meta  <= rxd;
            rxd_sync  <= rxd_meta;
            rxd_prev  <= rxd_sync;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign rx_fall  = rxd_prev & ~rxd_sync;
    assign tick     = (div_cnt == DIV_LAST);
    assign mid_last = (samp_cnt == SAMP_C);
    assign bit_end  = (samp_cnt == SAMP_LAST);
    assign maj      = (samp_a & samp_b) | (samp_a & rxd_sync) | (samp_b & rxd_sync);
    assign ack_rise = arx_ack & ~ack_q;
    assign arx_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt        <= '0;
            samp_cnt       <= '0;
            samp_a         <= 1'b1;
            samp_b         <= 1'b1;
            bit_cnt        <= 3'd0;
            shreg          <= 8'h00;
            line_seen_idle <= 1'b0;
        end else begin
            if (tick && sync_fill[1] && rxd_sync)
                line_seen_idle <= 1'b1;
            if (start_det) begin
                div_cnt  <= '0;
                samp_cnt <= '0;
                bit_cnt  <= 3'd0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    samp_cnt <= bit_end ? '0 : samp_cnt + 1'b1;
                    if (samp_cnt == SAMP_A) samp_a <= rxd_sync;
                    if (samp_cnt == SAMP_B) samp_b <= rxd_sync;
                    if (state == DATA && mid_last) shreg <= {maj, shreg[7:1]};
                    if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_nx  = state;
        start_det = 1'b0;
        deliver   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fall && line_seen_idle) begin
                    state_nx  = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (tick && mid_last && maj) state_nx = IDLE;
                else if (tick && bit_end)    state_nx = DATA;
            end
            DATA: begin
                if (tick && bit_end && bit_cnt == 3'd7) state_nx = STOP;
            end
            STOP: begin
                // Leave at mid-bit so a start bit right after the stop bit is not missed.
                if (tick && mid_last) begin
                    state_nx = IDLE;
                    deliver  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, push;

    assign empty      = (wr_ptr == rd_ptr);
    assign store_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = ack_rise & ~empty;
    assign push       = deliver & (~store_full | pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage array left unreset; the empty mux below gives arx_data its reset value.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    assign arx_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign arx_ready = ~empty;
`else
    logic [7:0] hold_data;
    logic       hold_full;

    assign store_full = hold_full;
    assign pop        = ack_rise & hold_full;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_data <= 8'h00;
            hold_full <= 1'b0;
        end else if (deliver && (!hold_full || pop)) begin
            hold_data <= shreg;
            hold_full <= 1'b1;
        end else if (pop) begin
            hold_full <= 1'b0;
        end
    end

    assign arx_data  = hold_data;
    assign arx_ready = hold_full;
`endif

    // A new error in the same clock as an ack edge wins over the clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack_q         <= 1'b0;
            arx_frame_err <= 1'b0;
            arx_overrun   <= 1'b0;
        end else begin
            ack_q         <= arx_ack;
            arx_frame_err <= (arx_frame_err & ~ack_rise) | (deliver & ~maj);
            arx_overrun   <= (arx_overrun & ~ack_rise) | (deliver & store_full & ~pop);
        end
    end

endmodule

// File: tb/tb_uart_rx_port.sv
// Self-checking bench for uart_rx_port: randomized frames scored against a queue model of the
// CPU-visible storage. Compile with +define+UART_RX_FIFO_EN to score the FIFO build.
module tb_uart_rx_port;

    localparam int CLK_HZ     = 3_200_000;
    localparam int BAUD       = 100_000;
    localparam int OS         = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_RAW    = (CLK_HZ + (BAUD * OS) / 2) / (BAUD * OS);
    localparam int DIV        = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int BIT        = OS * DIV;
    // Clocks from the first edge that samples the start bit to the edge that delivers the byte:
    // 2 synchroniser clocks, then the tick count restarts on entering START and the stop-bit
    // decision is taken on the third mid-bit tick of bit 9 (tick number 9*OS + OS/2 + 2).
    localparam int DELIV      = 2 + (9 * OS + OS / 2 + 2) * DIV;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       arx_ack = 1'b0;
    logic [7:0] arx_data;
    logic       arx_ready, arx_busy, arx_frame_err, arx_overrun;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [7:0] q[$];
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;

    uart_rx_port #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rxd(rxd), .arx_ack(arx_ack),
        .arx_data(arx_data), .arx_ready(arx_ready), .arx_busy(arx_busy),
        .arx_frame_err(arx_frame_err), .arx_overrun(arx_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d passed so far", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    // Storage model: a byte lands if there is room, otherwise it is lost and overrun is flagged.
    task automatic model_deliver(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit) m_ferr = 1'b1;
        if (q.size() < CAP) q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic model_ack();
        if (q.size() > 0) void'(q.pop_front());
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Must be called at a falling clock edge; drives one 8N1 frame, one bit per BIT clocks.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (BIT) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        send_frame(b, stop_bit);
        model_deliver(b, stop_bit);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_ack();
        arx_ack = 1'b1;
        @(negedge clk);
        arx_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rxd     = 1'b1;
        arx_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({arx_data, arx_ready, arx_busy, arx_frame_err, arx_overrun} !== 12'h000)
            $display("FAIL reset_outputs: got %h want 000",
                     {arx_data, arx_ready, arx_busy, arx_frame_err, arx_overrun});
        else n_pass++;
        reset_n = 1'b1;
        repeat (4 * DIV + 8) @(negedge clk);
        n_chk++;
        if ({arx_ready, arx_busy} !== 2'b00)
            $display("FAIL idle_after_reset: ready/busy=%b want 00", {arx_ready, arx_busy});
        else n_pass++;
    endtask

    task automatic test_basic();
        int t_del;
        @(negedge clk);
        t_del = cyc + 1 + DELIV;
        fork
            send_frame(8'h55, 1'b1);
            begin
                while (cyc < t_del - 1) @(negedge clk);
                n_chk++;
                if ({arx_ready, arx_busy} !== 2'b01)
                    $display("FAIL pre_delivery_55: ready/busy=%b want 01", {arx_ready, arx_busy});
                else n_pass++;
                @(negedge clk);
                n_chk++;
                if ({arx_ready, arx_busy, arx_data} !== {2'b10, 8'h55})
                    $display("FAIL delivery_55: ready/busy/data=%b/%h want 10/55",
                             {arx_ready, arx_busy}, arx_data);
                else n_pass++;
            end
        join
        model_deliver(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        arx_ack = 1'b1;
        @(negedge clk);
        model_ack();
        n_chk++;
        if (arx_ready !== 1'b0) $display("FAIL ack_pop_55: ready=%b want 0", arx_ready);
        else n_pass++;
        // Ack is still held high while 0xA0 arrives: no second pop may happen.
        rx_frame(8'hA0, 1'b1);
        n_chk++;
        if ({arx_ready, arx_data} !== {1'b1, q[0]})
            $display("FAIL held_ack_a0: ready/data=%b/%h want 1/%h", arx_ready, arx_data, q[0]);
        else n_pass++;
        arx_ack = 1'b0;
        @(negedge clk);
        do_ack();
        model_ack();
        n_chk++;
        if (arx_ready !== (q.size() != 0))
            $display("FAIL ack_pop_a0: ready=%b want %b", arx_ready, q.size() != 0);
        else n_pass++;
    endtask

    task automatic test_glitch();
        logic saw_busy = 1'b0;
        @(negedge clk);
        rxd = 1'b0;
        for (int i = 0; i < 3 * BIT; i++) begin
            if (i == (OS / 4) * DIV) rxd = 1'b1;
            @(negedge clk);
            if (arx_busy) saw_busy = 1'b1;
        end
        n_chk++;
        if (saw_busy !== 1'b1) $display("FAIL glitch_busy_pulse: seen=%b want 1", saw_busy);
        else n_pass++;
        n_chk++;
        if ({arx_busy, arx_ready, arx_frame_err} !== {1'b0, q.size() != 0, m_ferr})
            $display("FAIL glitch_rejected: busy/ready/ferr=%b want 0%b%b",
                     {arx_busy, arx_ready, arx_frame_err}, q.size() != 0, m_ferr);
        else n_pass++;
    endtask

    task automatic test_frame_err();
        rx_frame(8'h41, 1'b0);
        n_chk++;
        if ({arx_ready, arx_frame_err, arx_data} !== {2'b11, 8'h41})
            $display("FAIL frame_err_41: ready/ferr/data=%b/%h want 11/41",
                     {arx_ready, arx_frame_err}, arx_data);
        else n_pass++;
        do_ack();
        model_ack();
        n_chk++;
        if ({arx_ready, arx_frame_err} !== {q.size() != 0, m_ferr})
            $display("FAIL frame_err_clear: ready/ferr=%b want %b%b",
                     {arx_ready, arx_frame_err}, q.size() != 0, m_ferr);
        else n_pass++;
    endtask

    task automatic test_overrun();
        logic [7:0] vals [CAP + 1];
        for (int i = 0; i <= CAP; i++) begin
            vals[i] = 8'($urandom);
            rx_frame(vals[i], (i == CAP) ? 1'b0 : 1'b1);
        end
        n_chk++;
        if ({arx_ready, arx_overrun, arx_frame_err, arx_data} !== {3'b111, vals[0]})
            $display("FAIL overrun_set: ready/ovr/ferr/data=%b/%h want 111/%h",
                     {arx_ready, arx_overrun, arx_frame_err}, arx_data, vals[0]);
        else n_pass++;
        for (int i = 0; i < CAP; i++) begin
            do_ack();
            model_ack();
            n_chk++;
            if ({arx_ready, arx_overrun, arx_frame_err} !== {q.size() != 0, m_ovr, m_ferr})
                $display("FAIL overrun_pop%0d: ready/ovr/ferr=%b want %b%b%b", i,
                         {arx_ready, arx_overrun, arx_frame_err}, q.size() != 0, m_ovr, m_ferr);
            else n_pass++;
            if (q.size() != 0) begin
                n_chk++;
                if (arx_data !== q[0])
                    $display("FAIL overrun_head%0d: data=%h want %h", i, arx_data, q[0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b1, b2;
        int t_del;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        rx_frame(b1, 1'b1);
        @(negedge clk);
        t_del = cyc + 1 + DELIV;
        fork
            send_frame(b2, 1'b1);
            begin
                // Ack edge lands on the very clock that delivers b2.
                while (cyc < t_del - 1) @(negedge clk);
                arx_ack = 1'b1;
                @(negedge clk);
                n_chk++;
                if ({arx_ready, arx_overrun, arx_data} !== {2'b10, b2})
                    $display("FAIL pop_and_deliver: ready/ovr/data=%b/%h want 10/%h",
                             {arx_ready, arx_overrun}, arx_data, b2);
                else n_pass++;
                arx_ack = 1'b0;
            end
        join
        model_ack();
        model_deliver(b2, 1'b1);
        repeat (4) @(negedge clk);
        do_ack();
        model_ack();
        n_chk++;
        if ({arx_ready, arx_overrun} !== {q.size() != 0, m_ovr})
            $display("FAIL back_to_back_drain: ready/ovr=%b want %b%b",
                     {arx_ready, arx_overrun}, q.size() != 0, m_ovr);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop_bit;
        for (int k = 0; k < 6; k++) begin
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            rx_frame(b, stop_bit);
            n_chk++;
            if ({arx_ready, arx_frame_err, arx_overrun, arx_busy} !== {q.size() != 0, m_ferr, m_ovr, 1'b0})
                $display("FAIL random%0d_status: ready/ferr/ovr/busy=%b want %b%b%b0", k,
                         {arx_ready, arx_frame_err, arx_overrun, arx_busy}, q.size() != 0, m_ferr, m_ovr);
            else n_pass++;
            n_chk++;
            if (arx_data !== q[0]) $display("FAIL random%0d_data: data=%h want %h", k, arx_data, q[0]);
            else n_pass++;
            if ($urandom_range(0, 1) == 1) begin
                do_ack();
                model_ack();
                n_chk++;
                if ({arx_ready, arx_frame_err, arx_overrun} !== {q.size() != 0, m_ferr, m_ovr})
                    $display("FAIL random%0d_ack: ready/ferr/ovr=%b want %b%b%b", k,
                             {arx_ready, arx_frame_err, arx_overrun}, q.size() != 0, m_ferr, m_ovr);
                else n_pass++;
            end
        end
        while (q.size() > 0) begin
            do_ack();
            model_ack();
        end
        n_chk++;
        if (arx_ready !== 1'b0) $display("FAIL random_drain: ready=%b want 0", arx_ready);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic saw_busy = 1'b0;
        @(negedge clk);
        rxd = 1'b0;
        repeat (BIT + BIT / 2) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        for (int i = 0; i < 3 * BIT; i++) begin
            @(negedge clk);
            if (arx_busy) saw_busy = 1'b1;
        end
        n_chk++;
        if ({saw_busy, arx_ready} !== 2'b00)
            $display("FAIL reset_midframe_quiet: busy_seen/ready=%b want 00", {saw_busy, arx_ready});
        else n_pass++;
        rxd = 1'b1;
        repeat (BIT) @(negedge clk);
        rx_frame(8'h0D, 1'b1);
        n_chk++;
        if ({arx_ready, arx_frame_err, arx_data} !== {2'b10, 8'h0D})
            $display("FAIL reset_midframe_0d: ready/ferr/data=%b/%h want 10/0d",
                     {arx_ready, arx_frame_err}, arx_data);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
